// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle phase sequencer for the 8-bit MIPS datapath: FETCH/DECODE/EXEC/MEM/WB with a tick prescaler.
// Optional single-step input enabled by defining MIPS_SEQ_STEP_EN.
module mips_multicycle_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             run,
   input  logic             halt_req,
`ifdef MIPS_SEQ_STEP_EN
   input  logic             step,
`endif
   input  logic [1:0]       instr_op,
   output logic             ir_load,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_J   = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    cnt_reg;
   logic [1:0]       op_reg, op_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             tick, terminal, active, count_en;
   logic             step_pend_reg, single_reg;

`ifdef MIPS_SEQ_STEP_EN
   logic step_q_reg, step_qq_reg;

   // A step edge is only armed from IDLE with run low; edges while busy are discarded.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         step_q_reg    <= 1'b0;
         step_qq_reg   <= 1'b0;
         step_pend_reg <= 1'b0;
         single_reg    <= 1'b0;
      end else begin
         step_q_reg  <= step;
         step_qq_reg <= step_q_reg;
         if (state_reg != IDLE)
            step_pend_reg <= 1'b0;
         else if (step_q_reg && !step_qq_reg && !run)
            step_pend_reg <= 1'b1;
         if (state_reg == IDLE)
            single_reg <= step_pend_reg && !(run && !halt_req);
      end
   end
`else
   assign step_pend_reg = 1'b0;
   assign single_reg    = 1'b0;
`endif

   assign tick     = (cnt_reg == LAST);
   assign active   = (state_reg == DECODE) || (state_reg == EXEC) ||
                     (state_reg == MEM)    || (state_reg == WB);
   assign busy     = active || (state_reg == FETCH);
   assign count_en = busy || run || step_pend_reg;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= OP_ADD;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         count_reg <= count_next;
         if (!count_en || cnt_reg == LAST)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      count_next = count_reg;
      terminal   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tick && ((run && !halt_req) || step_pend_reg))
               state_next = FETCH;
         end
         FETCH: begin
            if (tick) begin
               op_next    = instr_op;
               state_next = DECODE;
            end
         end
         DECODE: begin
            if (tick)
               state_next = EXEC;
         end
         EXEC: begin
            if (tick) begin
               if (op_reg == OP_ADD)
                  state_next = WB;
               else if (op_reg == OP_J)
                  terminal = 1'b1;
               else
                  state_next = MEM;
            end
         end
         MEM: begin
            if (tick) begin
               if (op_reg == OP_LW)
                  state_next = WB;
               else
                  terminal = 1'b1;
            end
         end
         WB: terminal = tick;
         default: state_next = IDLE;
      endcase
      // run/halt_req only matter at instruction boundaries.
      if (terminal) begin
         count_next = count_reg + 1'b1;
         state_next = (run && !halt_req && !single_reg) ? FETCH : IDLE;
      end
   end

   assign ir_load     = (state_reg == FETCH);
   assign reg_dst     = active && (op_reg == OP_ADD);
   assign alu_op      = active && (op_reg == OP_ADD);
   assign alu_src     = active && ((op_reg == OP_LW) || (op_reg == OP_SW));
   assign mem_to_reg  = active && (op_reg == OP_LW);
   assign mem_read    = (op_reg == OP_LW) && ((state_reg == MEM) || (state_reg == WB));
   assign pc_sel      = (op_reg == OP_J) && (state_reg == EXEC);
   assign mem_write   = (op_reg == OP_SW) && (state_reg == MEM) && tick;
   assign reg_write   = (state_reg == WB) && tick &&
                        ((op_reg == OP_ADD) || (op_reg == OP_LW));
   assign pc_en       = terminal;
   assign state       = state_reg;
   assign instr_count = count_reg;
endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed bench for mips_multicycle_sequencer: one instance at TICK_DIV=1, one at TICK_DIV=3.
module tb_mips_multicycle_sequencer;
   localparam logic [10:0] IR   = 11'h400;
   localparam logic [10:0] PCEN = 11'h200;
   localparam logic [10:0] PCS  = 11'h100;
   localparam logic [10:0] RDST = 11'h080;
   localparam logic [10:0] ASRC = 11'h040;
   localparam logic [10:0] AOP  = 11'h020;
   localparam logic [10:0] MRD  = 11'h010;
   localparam logic [10:0] MWR  = 11'h008;
   localparam logic [10:0] M2R  = 11'h004;
   localparam logic [10:0] RW   = 11'h002;
   localparam logic [10:0] BSY  = 11'h001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1_n, run1, halt1;
   logic [1:0]  op1;
   logic [10:0] c1;
   logic [2:0]  st1;
   logic [7:0]  cnt1;
   logic        rst3_n, run3, halt3;
   logic [1:0]  op3;
   logic [10:0] c3;
   logic [2:0]  st3;
   logic [7:0]  cnt3;
`ifdef MIPS_SEQ_STEP_EN
   logic        step1, step3;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_cnt1;
   int          len_tab [4];
   logic [2:0]  st_tab  [4][5];
   logic [10:0] ct_tab  [4][5];

   mips_multicycle_sequencer #(.TICK_DIV(1), .CNT_W(8)) dut1 (
      .Clk(clk), .Reset(rst1_n), .run(run1), .halt_req(halt1),
`ifdef MIPS_SEQ_STEP_EN
      .step(step1),
`endif
      .instr_op(op1),
      .ir_load(c1[10]), .pc_en(c1[9]), .pc_sel(c1[8]), .reg_dst(c1[7]),
      .alu_src(c1[6]), .alu_op(c1[5]), .mem_read(c1[4]), .mem_write(c1[3]),
      .mem_to_reg(c1[2]), .reg_write(c1[1]), .busy(c1[0]),
      .state(st1), .instr_count(cnt1)
   );

   mips_multicycle_sequencer #(.TICK_DIV(3), .CNT_W(8)) dut3 (
      .Clk(clk), .Reset(rst3_n), .run(run3), .halt_req(halt3),
`ifdef MIPS_SEQ_STEP_EN
      .step(step3),
`endif
      .instr_op(op3),
      .ir_load(c3[10]), .pc_en(c3[9]), .pc_sel(c3[8]), .reg_dst(c3[7]),
      .alu_src(c3[6]), .alu_op(c3[5]), .mem_read(c3[4]), .mem_write(c3[3]),
      .mem_to_reg(c3[2]), .reg_write(c3[1]), .busy(c3[0]),
      .state(st3), .instr_count(cnt3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full instruction on dut1; op is disturbed after latching, optionally run drops mid-way.
   task automatic do_instr1(input logic [1:0] op, input bit stop);
      op1 = op;
      for (int p = 0; p < len_tab[op]; p++) begin
         @(negedge clk);
         check($sformatf("op%0d_state%0d", op, p), 32'(st1), 32'(st_tab[op][p]));
         check($sformatf("op%0d_ctl%0d", op, p), 32'(c1), 32'(ct_tab[op][p]));
         if (p == 0) check($sformatf("op%0d_count", op), 32'(cnt1), 32'(exp_cnt1));
         if (p == 1) begin
            op1 = ~op;
            if (stop) run1 = 1'b0;
         end
      end
      exp_cnt1 = exp_cnt1 + 8'd1;
      $display("instr op=%0d retired count=%0d", op, exp_cnt1);
   endtask

   initial begin
      len_tab = '{4, 5, 4, 3};
      st_tab[0] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
      st_tab[1] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      st_tab[2] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      st_tab[3] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
      ct_tab[0] = '{IR|BSY, RDST|AOP|BSY, RDST|AOP|BSY, RDST|AOP|RW|PCEN|BSY, 11'h0};
      ct_tab[1] = '{IR|BSY, ASRC|M2R|BSY, ASRC|M2R|BSY, ASRC|M2R|MRD|BSY,
                    ASRC|M2R|MRD|RW|PCEN|BSY};
      ct_tab[2] = '{IR|BSY, ASRC|BSY, ASRC|BSY, ASRC|MWR|PCEN|BSY, 11'h0};
      ct_tab[3] = '{IR|BSY, BSY, PCS|PCEN|BSY, 11'h0, 11'h0};

      rst1_n = 1'b0; run1 = 1'b0; halt1 = 1'b0; op1 = 2'b00;
      rst3_n = 1'b0; run3 = 1'b0; halt3 = 1'b0; op3 = 2'b00;
`ifdef MIPS_SEQ_STEP_EN
      step1 = 1'b0; step3 = 1'b0;
`endif
      #1;
      check("rst_state1", 32'(st1), 32'd0);
      check("rst_ctl1", 32'(c1), 32'd0);
      check("rst_count1", 32'(cnt1), 32'd0);
      check("rst_state3", 32'(st3), 32'd0);
      check("rst_ctl3", 32'(c3), 32'd0);
      repeat (2) @(negedge clk);
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      @(negedge clk);
      check("idle_norun", 32'(st1), 32'd0);

      // Continuous execution of each opcode at TICK_DIV=1.
      exp_cnt1 = 8'd0;
      run1 = 1'b1;
      repeat (3) do_instr1(2'b00, 1'b0);
      repeat (2) do_instr1(2'b01, 1'b0);
      repeat (2) do_instr1(2'b10, 1'b0);
      repeat (2) do_instr1(2'b11, 1'b0);

      // Reset asserted while an LW sits in MEM.
      op1 = 2'b01;
      repeat (4) @(negedge clk);
      check("lw_mem_state", 32'(st1), 32'd4);
      check("lw_mem_count", 32'(cnt1), 32'(exp_cnt1));
      rst1_n = 1'b0;
      #1;
      check("async_rst_state", 32'(st1), 32'd0);
      check("async_rst_ctl", 32'(c1), 32'd0);
      check("async_rst_count", 32'(cnt1), 32'd0);
      @(posedge clk);
      #1;
      check("held_rst_state", 32'(st1), 32'd0);
      check("held_rst_ctl", 32'(c1), 32'd0);
      @(negedge clk);
      rst1_n = 1'b1;
      exp_cnt1 = 8'd0;

      // 256 jumps wrap the retired counter back to 0, seen at the next FETCH.
      repeat (256) do_instr1(2'b11, 1'b0);
      do_instr1(2'b00, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("stopped_state", 32'(st1), 32'd0);
         check("stopped_ctl", 32'(c1), 32'd0);
         check("stopped_count", 32'(cnt1), 32'(exp_cnt1));
      end

      // TICK_DIV=3: LW with halt_req raised during DECODE and held past the boundary.
      op3 = 2'b01;
      run3 = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("d3_idle_wait", 32'(st3), 32'd0);
      end
      for (int p = 0; p < 5; p++) begin
         for (int s = 0; s < 3; s++) begin
            logic [10:0] exp_ctl;
            @(negedge clk);
            exp_ctl = ct_tab[1][p];
            if (p == 4 && s != 2) exp_ctl = exp_ctl & ~(PCEN | RW);
            check($sformatf("d3_state%0d_%0d", p, s), 32'(st3), 32'(st_tab[1][p]));
            check($sformatf("d3_ctl%0d_%0d", p, s), 32'(c3), 32'(exp_ctl));
            if (p == 1 && s == 0) halt3 = 1'b1;
            if (p == 2 && s == 0) op3 = 2'b00;
         end
      end
      $display("instr tick_div=3 op=1 halted");
      repeat (4) begin
         @(negedge clk);
         check("d3_halted_state", 32'(st3), 32'd0);
         check("d3_halted_ctl", 32'(c3), 32'd0);
         check("d3_halted_count", 32'(cnt3), 32'd1);
      end
      halt3 = 1'b0;
      run3 = 1'b0;

`ifdef MIPS_SEQ_STEP_EN
      begin
         int pc_pulses;
         int rw_pulses;
         pc_pulses = 0;
         rw_pulses = 0;
         op1 = 2'b00;
         step1 = 1'b1;
         repeat (20) begin
            @(negedge clk);
            if (c1[9]) pc_pulses++;
            if (c1[1]) rw_pulses++;
         end
         step1 = 1'b0;
         exp_cnt1 = exp_cnt1 + 8'd1;
         check("step_pc_en_pulses", 32'(pc_pulses), 32'd1);
         check("step_reg_write_pulses", 32'(rw_pulses), 32'd1);
         check("step_final_state", 32'(st1), 32'd0);
         check("step_count", 32'(cnt1), 32'(exp_cnt1));
         $display("instr step op=0 retired count=%0d", exp_cnt1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
